placement_grid_reader: RTL and testbench

- Consumer side of the placement grid RAM. After placement finishes, this block scans every grid cell in raster order and streams each occupied cell out as a (node, x, y) record over a valid/ready interface.
- While scanning it checks the grid: it counts occupied cells, flags node ids that appear more than once, and flags node ids that are out of range.
- It sits beside the placement engine, shares the grid RAM read port once placement is done, and feeds dump/route logic downstream.

---
 rtl/placement_grid_reader.sv | 145 ++++++++++++++
 tb/tb_placement_grid_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/placement_grid_reader.sv
// Raster-scans the placement grid RAM and streams each occupied cell as (node, x, y), checking for duplicate and out-of-range ids.
// Latency: 4 cycles per cell plus 1 per emitted record and any stall cycles; backpressure holds the record in EMIT until out_ready.
module placement_grid_reader #(
   parameter int          N     = 6,
   parameter int          V     = 11,
   parameter logic [31:0] EMPTY = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        grid_re,
   output logic [31:0] grid_addr,
   input  logic [31:0] grid_dout,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_node,
   output logic [31:0] out_x,
   output logic [31:0] out_y,
   output logic [31:0] count,
   output logic        err_dup,
   output logic        err_range
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = (V > 1) ? $clog2(V) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_CHECK,
      S_EMIT,
      S_ADV,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   x;
   logic [CW-1:0]   y;
   logic [31:0]     addr;
   logic [V-1:0]    seen;
   logic signed [31:0] node_s;
   logic [IW-1:0]   idx;
   logic            is_empty;
   logic            in_range;
   logic            last;

   assign node_s   = grid_dout;
   assign idx      = grid_dout[IW-1:0];
   assign is_empty = (grid_dout == EMPTY);
   assign in_range = (node_s >= 0) && (node_s < V);
   assign last     = (x == CW'(N - 1)) && (y == CW'(N - 1));

   assign grid_re   = (state == S_READ);
   assign done      = (state == S_DONE);
   assign grid_addr = addr;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_READ;
         S_READ:  state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_CHECK;
         S_CHECK: begin
            if (!is_empty && in_range) state_nxt = S_EMIT;
            else                       state_nxt = S_ADV;
         end
         S_EMIT:  if (out_ready) state_nxt = S_ADV;
         S_ADV:   state_nxt = last ? S_DONE : S_READ;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         x         <= '0;
         y         <= '0;
         addr      <= '0;
         seen      <= '0;
         count     <= '0;
         err_dup   <= 1'b0;
         err_range <= 1'b0;
         out_valid <= 1'b0;
         out_node  <= '0;
         out_x     <= '0;
         out_y     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  x         <= '0;
                  y         <= '0;
                  addr      <= '0;
                  seen      <= '0;
                  count     <= '0;
                  err_dup   <= 1'b0;
                  err_range <= 1'b0;
               end
            end
            S_CHECK: begin
               if (!is_empty) begin
                  if (in_range) begin
                     count <= count + 32'd1;
                     // duplicates are flagged but still forwarded downstream
                     if (seen[idx]) err_dup <= 1'b1;
                     else           seen[idx] <= 1'b1;
                     out_valid <= 1'b1;
                     out_node  <= grid_dout;
                     out_x     <= 32'(x);
                     out_y     <= 32'(y);
                  end else begin
                     err_range <= 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            S_ADV: begin
               // raster order means the linear address simply increments
               if (!last) begin
                  addr <= addr + 32'd1;
                  if (y == CW'(N - 1)) begin
                     y <= '0;
                     x <= x + 1'b1;
                  end else begin
                     y <= y + 1'b1;
                  end
               end
            end
            S_DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_placement_grid_reader.sv
// Randomized and directed bench for placement_grid_reader with a list-based reference model of the grid scan.
module tb_placement_grid_reader;

   localparam int          N     = 3;
   localparam int          V     = 4;
   localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] grid_dout = '0;
   logic        busy, done, grid_re, out_valid, err_dup, err_range;
   logic [31:0] grid_addr, out_node, out_x, out_y, count;

   placement_grid_reader #(.N(N), .V(V), .EMPTY(EMPTY)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .grid_re(grid_re), .grid_addr(grid_addr), .grid_dout(grid_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
      .out_x(out_x), .out_y(out_y), .count(count), .err_dup(err_dup),
      .err_range(err_range)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [N*N];
   always @(posedge clk) if (grid_re && grid_addr < N*N) grid_dout <= mem[grid_addr];

   int vectors = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: expected record list and final status from the grid contents
   int exp_node[$], exp_x[$], exp_y[$];
   int exp_count;
   bit exp_dup, exp_range;

   task automatic build_model();
      int occ [V];
      int v;
      exp_node.delete(); exp_x.delete(); exp_y.delete();
      exp_count = 0; exp_dup = 0; exp_range = 0;
      foreach (occ[i]) occ[i] = 0;
      for (int a = 0; a < N*N; a++) begin
         v = $signed(mem[a]);
         if (mem[a] == EMPTY) continue;
         if (v >= 0 && v < V) begin
            exp_node.push_back(v);
            exp_x.push_back(a / N);
            exp_y.push_back(a % N);
            exp_count++;
            occ[v]++;
            if (occ[v] >= 2) exp_dup = 1;
         end else begin
            exp_range = 1;
         end
      end
   endtask

   task automatic load_grid(input int cells[$], input int vals[$]);
      for (int a = 0; a < N*N; a++) mem[a] = EMPTY;
      foreach (cells[i]) mem[cells[i]] = 32'(vals[i]);
      build_model();
   endtask

   // mode 0: ready high; 1: ready low for 5 cycles at first record; 2: random ready.
   // abort_at > 0 resets the DUT while record number abort_at is being offered.
   task automatic run_scan(input int mode, input int abort_at, output int elapsed);
      int got = 0, exp_addr = 0, stall = 0, vrun = 0, first_re = -1, start_cyc, done_cyc = -1;
      bit hold = 0, released = 0, next_ready, seen_done = 0;
      logic [31:0] hn, hx, hy;
      elapsed = -1;
      out_ready = (mode == 1) ? 1'b0 : 1'b1;
      next_ready = out_ready;
      @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
      @(posedge clk); #1 start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      for (int b = 0; b < 2000; b++) begin
         @(negedge clk);
         if (grid_re) begin
            if (first_re < 0) first_re = cyc;
            check_eq("grid_addr", grid_addr, 32'(exp_addr));
            exp_addr++;
         end
         if (done) begin seen_done = 1; done_cyc = cyc; break; end
         if (out_valid) begin
            vrun++;
            if (hold) begin
               check_eq("hold_node", out_node, hn);
               check_eq("hold_x", out_x, hx);
               check_eq("hold_y", out_y, hy);
            end
            if (abort_at > 0 && got == abort_at - 1) begin
               check_eq("pre_abort_count", count, 32'(exp_count > 0 ? got + 1 : 0));
               reset = 1'b0;
               #1;
               check_eq("abort_valid", 32'(out_valid), 32'd0);
               check_eq("abort_busy", 32'(busy), 32'd0);
               check_eq("abort_count", count, 32'd0);
               check_eq("abort_dup", 32'(err_dup), 32'd0);
               check_eq("abort_range", 32'(err_range), 32'd0);
               repeat (3) begin
                  @(negedge clk);
                  check_eq("abort_no_done", 32'(done), 32'd0);
               end
               reset = 1'b1;
               out_ready = 1'b1;
               return;
            end
            if (out_ready) begin
               if (got < exp_node.size()) begin
                  check_eq("rec_node", out_node, 32'(exp_node[got]));
                  check_eq("rec_x", out_x, 32'(exp_x[got]));
                  check_eq("rec_y", out_y, 32'(exp_y[got]));
               end else begin
                  check_eq("extra_record", 32'd1, 32'd0);
               end
               if (mode == 1 && got == 0) check_eq("stall_valid_cycles", 32'(vrun), 32'd6);
               got++;
               hold = 0;
               vrun = 0;
            end else begin
               hold = 1; hn = out_node; hx = out_x; hy = out_y;
               if (mode == 1) stall++;
            end
         end
         if (mode == 1) begin
            if (stall >= 5) released = 1;
            next_ready = released;
         end else if (mode == 2) begin
            next_ready = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #1 out_ready = next_ready;
      end
      if (!seen_done) begin
         check_eq("done_timeout", 32'd0, 32'd1);
      end else begin
         elapsed = done_cyc - start_cyc;
         check_eq("first_re_latency", 32'(first_re - start_cyc), 32'd1);
         check_eq("cells_read", 32'(exp_addr), 32'(N*N));
         check_eq("records", 32'(got), 32'(exp_node.size()));
         check_eq("count", count, 32'(exp_count));
         check_eq("err_dup", 32'(err_dup), 32'(exp_dup));
         check_eq("err_range", 32'(err_range), 32'(exp_range));
         @(posedge clk); #1;
         check_eq("busy_after_done", 32'(busy), 32'd0);
         check_eq("done_pulse", 32'(done), 32'd0);
         check_eq("count_hold", count, 32'(exp_count));
      end
      out_ready = 1'b1;
   endtask

   initial begin
      int t_fast, t_slow, t;
      int cells[$], vals[$];
      for (int a = 0; a < N*N; a++) mem[a] = EMPTY;
      #2;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_re", 32'(grid_re), 32'd0);
      check_eq("rst_count", count, 32'd0);
      check_eq("rst_flags", 32'({err_dup, err_range}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      cells = {}; vals = {};
      load_grid(cells, vals);
      run_scan(0, 0, t);
      check_eq("empty_done_cycles", 32'(t), 32'(4*N*N + 1));

      cells = {0, 4, 8}; vals = {2, 0, 3};
      load_grid(cells, vals);
      run_scan(0, 0, t_fast);
      run_scan(1, 0, t_slow);
      check_eq("stall_done_delay", 32'(t_slow - t_fast), 32'd5);

      cells = {1, 5}; vals = {1, 1};
      load_grid(cells, vals);
      run_scan(0, 0, t);

      cells = {3, 6}; vals = {7, -5};
      load_grid(cells, vals);
      run_scan(0, 0, t);

      cells = {0, 1, 4}; vals = {1, 1, 2};
      load_grid(cells, vals);
      run_scan(0, 2, t);
      run_scan(0, 0, t);

      for (int g = 0; g < 10; g++) begin
         int r;
         for (int a = 0; a < N*N; a++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       mem[a] = EMPTY;
            else if (r < 8)  mem[a] = 32'($urandom_range(0, V - 1));
            else if (r == 8) mem[a] = 32'(V + $urandom_range(0, 5));
            else             mem[a] = 32'(-2 - $urandom_range(0, 5));
         end
         build_model();
         run_scan(2, 0, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
